// File: rtl/gen_bounce_boxes_if.sv
// Pixel-stream link between the sync/timing generator and the box renderer:
// timing flags and coordinates in, registered 4:4:4 RGB out.
interface gen_bounce_boxes_if #(
  parameter int HW = 10,
  parameter int VW = 9
);
  logic          i_px_clk;
  logic          i_haddr_enb;
  logic          i_vaddr_enb;
  logic          i_frame_en;
  logic [HW-1:0] i_hidx;
  logic [VW-1:0] i_vidx;
  logic [3:0]    o_vga_red;
  logic [3:0]    o_vga_green;
  logic [3:0]    o_vga_blue;

  modport master (
    output i_px_clk, i_haddr_enb, i_vaddr_enb, i_frame_en, i_hidx, i_vidx,
    input  o_vga_red, o_vga_green, o_vga_blue
  );

  modport slave (
    input  i_px_clk, i_haddr_enb, i_vaddr_enb, i_frame_en, i_hidx, i_vidx,
    output o_vga_red, o_vga_green, o_vga_blue
  );
endinterface

// File: rtl/gen_bounce_boxes.sv
// NUM_BOX coloured boxes bouncing inside the active area, with registered RGB
// output and edge/corner hit events.
module gen_bounce_boxes #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int HW        = 10,
  parameter int VW        = 9,
  parameter int NUM_BOX   = 2,
  parameter int BOX_W     = 100,
  parameter int BOX_H     = 100,
  parameter int STEP      = 1,
  parameter int X0        = 100,
  parameter int Y0        = 100,
  parameter int X_SPACING = 120,
  parameter int Y_SPACING = 60,
  parameter logic [NUM_BOX*12-1:0] COLORS   = {12'h00F, 12'hF00},
  parameter logic [11:0]           BG_COLOR = 12'h000
) (
  input  logic                clk,
  input  logic                i_arst_n,
  input  logic                i_sclr,
  input  logic                i_pause,
  gen_bounce_boxes_if.slave   vid,
  output logic                o_edge_hit,
  output logic                o_corner_hit,
  output logic [15:0]         o_corner_cnt
);

  localparam logic [HW:0] XL     = (HW+1)'(H_ACTIVE - BOX_W);
  localparam logic [VW:0] YL     = (VW+1)'(V_ACTIVE - BOX_H);
  localparam logic [HW:0] STEP_X = (HW+1)'(STEP);
  localparam logic [VW:0] STEP_Y = (VW+1)'(STEP);
  localparam logic [HW:0] BOXW_X = (HW+1)'(BOX_W);
  localparam logic [VW:0] BOXH_Y = (VW+1)'(BOX_H);

  if (NUM_BOX < 1 || NUM_BOX > 8 || STEP < 1 || STEP > BOX_W) begin : g_bad_param
    $error("gen_bounce_boxes: NUM_BOX must be 1..8 and STEP 1..BOX_W");
  end

  for (genvar k = 0; k < NUM_BOX; k++) begin : g_chk
    if (X0 + k*X_SPACING > H_ACTIVE - BOX_W || X0 + k*X_SPACING < 0 ||
        Y0 + k*Y_SPACING > V_ACTIVE - BOX_H || Y0 + k*Y_SPACING < 0) begin : g_bad_init
      $error("gen_bounce_boxes: initial box position outside the active area");
    end
  end

  function automatic logic [HW-1:0] init_x(int unsigned k);
    return HW'(X0 + int'(k) * X_SPACING);
  endfunction

  function automatic logic [VW-1:0] init_y(int unsigned k);
    return VW'(Y0 + int'(k) * Y_SPACING);
  endfunction

  // Direction bit: 0 = increasing, 1 = decreasing; odd boxes start moving left.
  function automatic logic [NUM_BOX-1:0] init_dx();
    logic [NUM_BOX-1:0] d;
    d = '0;
    for (int unsigned k = 0; k < NUM_BOX; k++) d[k] = k[0];
    return d;
  endfunction

  logic [HW-1:0]      x_q   [NUM_BOX];
  logic [VW-1:0]      y_q   [NUM_BOX];
  logic [HW-1:0]      x_nxt [NUM_BOX];
  logic [VW-1:0]      y_nxt [NUM_BOX];
  logic [NUM_BOX-1:0] dx_q, dy_q, dx_nxt, dy_nxt, rev_x, rev_y;
  logic [11:0]        pix_d, rgb_q;
  logic [HW:0]        hx;
  logic [VW:0]        vy;

  always_comb begin
    logic [HW:0] x_inc;
    logic [VW:0] y_inc;
    x_inc  = '0;
    y_inc  = '0;
    dx_nxt = dx_q;
    dy_nxt = dy_q;
    rev_x  = '0;
    rev_y  = '0;
    for (int unsigned k = 0; k < NUM_BOX; k++) begin
      x_nxt[k] = x_q[k];
      y_nxt[k] = y_q[k];
      x_inc    = {1'b0, x_q[k]} + STEP_X;
      y_inc    = {1'b0, y_q[k]} + STEP_Y;
      if (!dx_q[k]) begin
        if (x_inc <= XL) x_nxt[k] = x_inc[HW-1:0];
        else begin
          x_nxt[k] = XL[HW-1:0]; dx_nxt[k] = 1'b1; rev_x[k] = 1'b1;
        end
      end else if ({1'b0, x_q[k]} >= STEP_X) x_nxt[k] = x_q[k] - STEP_X[HW-1:0];
      else begin
        x_nxt[k] = '0; dx_nxt[k] = 1'b0; rev_x[k] = 1'b1;
      end
      if (!dy_q[k]) begin
        if (y_inc <= YL) y_nxt[k] = y_inc[VW-1:0];
        else begin
          y_nxt[k] = YL[VW-1:0]; dy_nxt[k] = 1'b1; rev_y[k] = 1'b1;
        end
      end else if ({1'b0, y_q[k]} >= STEP_Y) y_nxt[k] = y_q[k] - STEP_Y[VW-1:0];
      else begin
        y_nxt[k] = '0; dy_nxt[k] = 1'b0; rev_y[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int unsigned k = 0; k < NUM_BOX; k++) begin
        x_q[k] <= init_x(k);
        y_q[k] <= init_y(k);
      end
      dx_q         <= init_dx();
      dy_q         <= '0;
      o_edge_hit   <= 1'b0;
      o_corner_hit <= 1'b0;
      o_corner_cnt <= '0;
    end else if (i_sclr) begin
      for (int unsigned k = 0; k < NUM_BOX; k++) begin
        x_q[k] <= init_x(k);
        y_q[k] <= init_y(k);
      end
      dx_q         <= init_dx();
      dy_q         <= '0;
      o_edge_hit   <= 1'b0;
      o_corner_hit <= 1'b0;
      o_corner_cnt <= '0;
    end else begin
      o_edge_hit   <= 1'b0;
      o_corner_hit <= 1'b0;
      if (vid.i_frame_en && !i_pause) begin
        for (int unsigned k = 0; k < NUM_BOX; k++) begin
          x_q[k] <= x_nxt[k];
          y_q[k] <= y_nxt[k];
        end
        dx_q         <= dx_nxt;
        dy_q         <= dy_nxt;
        o_edge_hit   <= |{rev_x, rev_y};
        o_corner_hit <= |(rev_x & rev_y);
        // One count per update, however many boxes hit a corner together.
        if (|(rev_x & rev_y)) o_corner_cnt <= o_corner_cnt + 16'd1;
      end
    end
  end

  assign hx = {1'b0, vid.i_hidx};
  assign vy = {1'b0, vid.i_vidx};

  // Scan from box 0 upward and keep the first hit, so box 0 is drawn on top.
  always_comb begin
    logic found;
    found = 1'b0;
    pix_d = '0;
    if (vid.i_haddr_enb && vid.i_vaddr_enb) begin
      pix_d = BG_COLOR;
      for (int unsigned k = 0; k < NUM_BOX; k++) begin
        if (!found &&
            hx >= {1'b0, x_q[k]} && hx < {1'b0, x_q[k]} + BOXW_X &&
            vy >= {1'b0, y_q[k]} && vy < {1'b0, y_q[k]} + BOXH_Y) begin
          pix_d = COLORS[12*k +: 12];
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n)          rgb_q <= '0;
    else if (i_sclr)        rgb_q <= '0;
    else if (vid.i_px_clk)  rgb_q <= pix_d;
  end

  assign vid.o_vga_red   = rgb_q[11:8];
  assign vid.o_vga_green = rgb_q[7:4];
  assign vid.o_vga_blue  = rgb_q[3:0];

endmodule

// File: tb/tb_gen_bounce_boxes.sv
// Bench for gen_bounce_boxes: a default two-box instance and a single-box
// instance starting at (160,0), both checked against a behavioural model.
module tb_gen_bounce_boxes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, sclr, pause;
  logic        edge_a, corner_a, edge_b, corner_b;
  logic [15:0] cnt_a, cnt_b;
  logic [11:0] rgb_a, rgb_b;

  gen_bounce_boxes_if #(.HW(10), .VW(9)) va ();
  gen_bounce_boxes_if #(.HW(10), .VW(9)) vb ();

  gen_bounce_boxes dut_a (
    .clk(clk), .i_arst_n(arst_n), .i_sclr(sclr), .i_pause(pause), .vid(va),
    .o_edge_hit(edge_a), .o_corner_hit(corner_a), .o_corner_cnt(cnt_a)
  );

  gen_bounce_boxes #(.NUM_BOX(1), .X0(160), .Y0(0), .COLORS(12'h0F0)) dut_b (
    .clk(clk), .i_arst_n(arst_n), .i_sclr(sclr), .i_pause(pause), .vid(vb),
    .o_edge_hit(edge_b), .o_corner_hit(corner_b), .o_corner_cnt(cnt_b)
  );

  assign rgb_a = {va.o_vga_red, va.o_vga_green, va.o_vga_blue};
  assign rgb_b = {vb.o_vga_red, vb.o_vga_green, vb.o_vga_blue};

  int n_checks = 0;
  int n_fail   = 0;

  // Model entries 0,1 are dut_a's boxes; entry 2 is dut_b's single box.
  int          mx [3];
  int          my [3];
  bit          mdx[3];
  bit          mdy[3];
  logic [15:0] mcnt_a, mcnt_b;
  logic [11:0] last_a, last_b;
  logic [11:0] qa[$], qb[$];
  int          pq_h[$], pq_v[$];

  function automatic bit covers(int i, int h, int v);
    return h >= mx[i] && h < mx[i] + 100 && v >= my[i] && v < my[i] + 100;
  endfunction

  function automatic logic [11:0] col_a(int h, int v, bit act);
    if (!act) return 12'h000;
    if (covers(0, h, v)) return 12'hF00;
    if (covers(1, h, v)) return 12'h00F;
    return 12'h000;
  endfunction

  function automatic logic [11:0] col_b(int h, int v, bit act);
    if (!act) return 12'h000;
    return covers(2, h, v) ? 12'h0F0 : 12'h000;
  endfunction

  task automatic model_reset();
    mx  = '{100, 220, 160};
    my  = '{100, 160, 0};
    mdx = '{0, 1, 0};
    mdy = '{0, 0, 0};
    mcnt_a = '0; mcnt_b = '0;
    last_a = '0; last_b = '0;
  endtask

  task automatic model_step(output bit e_a, c_a, e_b, c_b);
    bit rx[3], ry[3];
    for (int i = 0; i < 3; i++) begin
      rx[i] = 0; ry[i] = 0;
      if (!mdx[i]) begin
        if (mx[i] + 1 <= 540) mx[i]++; else begin mx[i] = 540; mdx[i] = 1; rx[i] = 1; end
      end else begin
        if (mx[i] >= 1) mx[i]--; else begin mx[i] = 0; mdx[i] = 0; rx[i] = 1; end
      end
      if (!mdy[i]) begin
        if (my[i] + 1 <= 380) my[i]++; else begin my[i] = 380; mdy[i] = 1; ry[i] = 1; end
      end else begin
        if (my[i] >= 1) my[i]--; else begin my[i] = 0; mdy[i] = 0; ry[i] = 1; end
      end
    end
    e_a = rx[0] | ry[0] | rx[1] | ry[1];
    c_a = (rx[0] & ry[0]) | (rx[1] & ry[1]);
    e_b = rx[2] | ry[2];
    c_b = rx[2] & ry[2];
    if (c_a) mcnt_a++;
    if (c_b) mcnt_b++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int h, int v, bit ha, bit vv, bit px, bit fe);
    va.i_hidx = 10'(h); va.i_vidx = 9'(v);
    va.i_haddr_enb = ha; va.i_vaddr_enb = vv; va.i_px_clk = px; va.i_frame_en = fe;
    vb.i_hidx = 10'(h); vb.i_vidx = 9'(v);
    vb.i_haddr_enb = ha; vb.i_vaddr_enb = vv; vb.i_px_clk = px; vb.i_frame_en = fe;
  endtask

  // Drives one pixel for a clock and queues the RGB each instance must show after it.
  task automatic send_pixel(int h, int v, bit ha, bit vv, bit px);
    drive(h, v, ha, vv, px, 1'b0);
    if (px) begin
      last_a = col_a(h, v, ha && vv);
      last_b = col_b(h, v, ha && vv);
    end
    qa.push_back(last_a);
    qb.push_back(last_b);
    tick();
  endtask

  task automatic send_strobe(output bit e_a, c_a, e_b, c_b);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (!pause) model_step(e_a, c_a, e_b, c_b);
    else begin e_a = 0; c_a = 0; e_b = 0; c_b = 0; end
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_probe(int i);
    pq_h.push_back(mx[i]);           pq_v.push_back(my[i]);
    pq_h.push_back(mx[i] + 99);      pq_v.push_back(my[i] + 99);
    if (mx[i] > 0)         begin pq_h.push_back(mx[i] - 1);   pq_v.push_back(my[i]);       end
    if (mx[i] + 100 < 640) begin pq_h.push_back(mx[i] + 100); pq_v.push_back(my[i]);       end
    if (my[i] > 0)         begin pq_h.push_back(mx[i]);       pq_v.push_back(my[i] - 1);   end
    if (my[i] + 100 < 480) begin pq_h.push_back(mx[i]);       pq_v.push_back(my[i] + 100); end
  endtask

  task automatic test_reset();
    int ph[3] = '{150, 300, 200};
    int pv[3] = '{150, 200, 50};
    logic [11:0] ea, eb;
    arst_n = 1'b0; sclr = 1'b0; pause = 1'b0;
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    n_checks += 6;
    if (rgb_a !== 12'h000) begin n_fail++; $display("FAIL reset_rgb_a: got %h expected 000", rgb_a); end
    if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL reset_rgb_b: got %h expected 000", rgb_b); end
    if ({edge_a, corner_a} !== 2'b00) begin n_fail++; $display("FAIL reset_pulse_a: got %b expected 00", {edge_a, corner_a}); end
    if ({edge_b, corner_b} !== 2'b00) begin n_fail++; $display("FAIL reset_pulse_b: got %b expected 00", {edge_b, corner_b}); end
    if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_a: got %0d expected 0", cnt_a); end
    if (cnt_b !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_b: got %0d expected 0", cnt_b); end
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_pixel(ph[i], pv[i], 1'b1, 1'b1, 1'b1);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (rgb_a !== ea) begin n_fail++; $display("FAIL init_rgb_a (%0d,%0d): got %h expected %h", ph[i], pv[i], rgb_a, ea); end
      if (rgb_b !== eb) begin n_fail++; $display("FAIL init_rgb_b (%0d,%0d): got %h expected %h", ph[i], pv[i], rgb_b, eb); end
    end
  endtask

  task automatic test_blanking();
    int ph[4] = '{150, 300, 150, 200};
    int pv[4] = '{150, 200, 150, 50};
    bit hh[4] = '{1, 1, 0, 1};
    bit pp[4] = '{1, 0, 1, 0};
    logic [11:0] ea, eb;
    for (int i = 0; i < 4; i++) begin
      send_pixel(ph[i], pv[i], hh[i], 1'b1, pp[i]);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (rgb_a !== ea) begin n_fail++; $display("FAIL blank_rgb_a step %0d: got %h expected %h", i, rgb_a, ea); end
      if (rgb_b !== eb) begin n_fail++; $display("FAIL blank_rgb_b step %0d: got %h expected %h", i, rgb_b, eb); end
    end
  endtask

  task automatic test_motion();
    bit e_a, c_a, e_b, c_b;
    int h, v;
    logic [11:0] ea, eb;
    for (int s = 1; s <= 442; s++) begin
      send_strobe(e_a, c_a, e_b, c_b);
      n_checks += 6;
      if (edge_a !== e_a)   begin n_fail++; $display("FAIL edge_a strobe %0d: got %b expected %b", s, edge_a, e_a); end
      if (corner_a !== c_a) begin n_fail++; $display("FAIL corner_a strobe %0d: got %b expected %b", s, corner_a, c_a); end
      if (cnt_a !== mcnt_a) begin n_fail++; $display("FAIL cnt_a strobe %0d: got %0d expected %0d", s, cnt_a, mcnt_a); end
      if (edge_b !== e_b)   begin n_fail++; $display("FAIL edge_b strobe %0d: got %b expected %b", s, edge_b, e_b); end
      if (corner_b !== c_b) begin n_fail++; $display("FAIL corner_b strobe %0d: got %b expected %b", s, corner_b, c_b); end
      if (cnt_b !== mcnt_b) begin n_fail++; $display("FAIL cnt_b strobe %0d: got %0d expected %0d", s, cnt_b, mcnt_b); end
      if (s == 441) begin
        tick();
        n_checks += 2;
        if (edge_a !== 1'b0)   begin n_fail++; $display("FAIL edge_a_width: got %b expected 0", edge_a); end
        if (corner_a !== 1'b0) begin n_fail++; $display("FAIL corner_a_width: got %b expected 0", corner_a); end
      end
      if (s == 380 || s == 381 || s == 440 || s == 441 || s == 442) begin
        add_probe(0); add_probe(2);
        while (pq_h.size() > 0) begin
          h = pq_h.pop_front(); v = pq_v.pop_front();
          send_pixel(h, v, 1'b1, 1'b1, 1'b1);
          ea = qa.pop_front(); eb = qb.pop_front();
          n_checks += 2;
          if (rgb_a !== ea) begin n_fail++; $display("FAIL pos_rgb_a strobe %0d (%0d,%0d): got %h expected %h", s, h, v, rgb_a, ea); end
          if (rgb_b !== eb) begin n_fail++; $display("FAIL pos_rgb_b strobe %0d (%0d,%0d): got %h expected %h", s, h, v, rgb_b, eb); end
        end
      end
    end
  endtask

  task automatic test_pause_sclr();
    bit e_a, c_a, e_b, c_b;
    int h, v;
    logic [11:0] ea, eb;
    pause = 1'b1;
    for (int s = 0; s < 10; s++) begin
      send_strobe(e_a, c_a, e_b, c_b);
      n_checks += 4;
      if ({edge_a, corner_a} !== {e_a, c_a}) begin n_fail++; $display("FAIL pause_pulse_a %0d: got %b expected %b", s, {edge_a, corner_a}, {e_a, c_a}); end
      if ({edge_b, corner_b} !== {e_b, c_b}) begin n_fail++; $display("FAIL pause_pulse_b %0d: got %b expected %b", s, {edge_b, corner_b}, {e_b, c_b}); end
      if (cnt_a !== mcnt_a) begin n_fail++; $display("FAIL pause_cnt_a %0d: got %0d expected %0d", s, cnt_a, mcnt_a); end
      if (cnt_b !== mcnt_b) begin n_fail++; $display("FAIL pause_cnt_b %0d: got %0d expected %0d", s, cnt_b, mcnt_b); end
    end
    pause = 1'b0;
    add_probe(0); add_probe(1); add_probe(2);
    while (pq_h.size() > 0) begin
      h = pq_h.pop_front(); v = pq_v.pop_front();
      send_pixel(h, v, 1'b1, 1'b1, 1'b1);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (rgb_a !== ea) begin n_fail++; $display("FAIL pause_rgb_a (%0d,%0d): got %h expected %h", h, v, rgb_a, ea); end
      if (rgb_b !== eb) begin n_fail++; $display("FAIL pause_rgb_b (%0d,%0d): got %h expected %h", h, v, rgb_b, eb); end
    end
    // Clear wins over a simultaneous strobe and an enabled pixel inside box 0.
    sclr = 1'b1;
    drive(mx[0], my[0], 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    sclr = 1'b0;
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    n_checks += 5;
    if (rgb_a !== 12'h000) begin n_fail++; $display("FAIL sclr_rgb_a: got %h expected 000", rgb_a); end
    if ({edge_a, corner_a, edge_b, corner_b} !== 4'b0000) begin n_fail++; $display("FAIL sclr_pulses: got %b expected 0000", {edge_a, corner_a, edge_b, corner_b}); end
    if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL sclr_cnt_a: got %0d expected 0", cnt_a); end
    if (cnt_b !== 16'd0) begin n_fail++; $display("FAIL sclr_cnt_b: got %0d expected 0", cnt_b); end
    if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL sclr_rgb_b: got %h expected 000", rgb_b); end
    add_probe(0); add_probe(1); add_probe(2);
    while (pq_h.size() > 0) begin
      h = pq_h.pop_front(); v = pq_v.pop_front();
      send_pixel(h, v, 1'b1, 1'b1, 1'b1);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (rgb_a !== ea) begin n_fail++; $display("FAIL sclr_pos_a (%0d,%0d): got %h expected %h", h, v, rgb_a, ea); end
      if (rgb_b !== eb) begin n_fail++; $display("FAIL sclr_pos_b (%0d,%0d): got %h expected %h", h, v, rgb_b, eb); end
    end
  endtask

  task automatic test_async_reset();
    bit e_a, c_a, e_b, c_b;
    int h, v;
    logic [11:0] ea, eb;
    for (int s = 0; s < 381; s++) send_strobe(e_a, c_a, e_b, c_b);
    send_pixel(mx[0], my[0], 1'b1, 1'b1, 1'b1);
    ea = qa.pop_front(); eb = qb.pop_front();
    n_checks += 2;
    if (rgb_a !== ea)     begin n_fail++; $display("FAIL pre_arst_rgb_a: got %h expected %h", rgb_a, ea); end
    if (cnt_b !== mcnt_b) begin n_fail++; $display("FAIL pre_arst_cnt_b: got %0d expected %0d", cnt_b, mcnt_b); end
    #3 arst_n = 1'b0;
    #1;
    n_checks += 4;
    if (rgb_a !== 12'h000) begin n_fail++; $display("FAIL arst_rgb_a: got %h expected 000", rgb_a); end
    if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL arst_rgb_b: got %h expected 000", rgb_b); end
    if ({edge_a, corner_a, edge_b, corner_b} !== 4'b0000) begin n_fail++; $display("FAIL arst_pulses: got %b expected 0000", {edge_a, corner_a, edge_b, corner_b}); end
    if ({cnt_a, cnt_b} !== 32'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d/%0d expected 0/0", cnt_a, cnt_b); end
    model_reset();
    #2 arst_n = 1'b1;
    add_probe(0); add_probe(1); add_probe(2);
    while (pq_h.size() > 0) begin
      h = pq_h.pop_front(); v = pq_v.pop_front();
      send_pixel(h, v, 1'b1, 1'b1, 1'b1);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (rgb_a !== ea) begin n_fail++; $display("FAIL arst_pos_a (%0d,%0d): got %h expected %h", h, v, rgb_a, ea); end
      if (rgb_b !== eb) begin n_fail++; $display("FAIL arst_pos_b (%0d,%0d): got %h expected %h", h, v, rgb_b, eb); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_blanking();
    test_motion();
    test_pause_sclr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
